// File: rtl/screen_scanout.sv
// ---------------------------------------------------------------------------
// screen_scanout
//   Bitmapped monochrome video scanout. The design generates VGA-style timing
//   from the single clock, which is also the pixel clock. It fetches one
//   framebuffer word per WORD_W pixels from a single-port RAM with 1-cycle
//   read latency and shifts the word out LSB first (LSB = leftmost pixel).
//   CPU accesses share the RAM port. They are refused only in the display-slot
//   cycles that the scanout reserves.
//
//   Optional feature: define SCREEN_PALETTE_EN to enable the run-time palette.
//   In that build, fg_rgb/bg_rgb are sampled once per frame (h=0, last line)
//   and take effect from the next frame. Without the macro, the colours are
//   fixed at fg=12'hFFF and bg=12'h000.
//
// Ports
//   clk, reset            sole clock / synchronous active-high reset
//   cpu_load              1 = write strobe, 0 = read
//   cpu_addr, cpu_din     CPU word address / write data
//   cpu_busy              1 in display-slot cycles (CPU must hold request)
//   cpu_dout              read data, updated one cycle after accepted read
//   mem_addr, mem_we,
//   mem_wdata, mem_rdata  single-port RAM, 1-cycle read latency
//   h_sync, v_sync        active-low sync, registered
//   red, green, blue      4-bit colour, registered
//   fg_rgb, bg_rgb        palette inputs {R[11:8], G[7:4], B[3:0]}
// ---------------------------------------------------------------------------
module screen_scanout #(
  parameter int unsigned WORD_W   = 16,
  parameter int unsigned FB_W     = 512,
  parameter int unsigned FB_H     = 256,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned ADDR_W   = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_load,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [WORD_W-1:0] cpu_din,
  output logic              cpu_busy,
  output logic [WORD_W-1:0] cpu_dout,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              h_sync,
  output logic              v_sync,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  input  logic [11:0]       fg_rgb,
  input  logic [11:0]       bg_rgb
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned WPR     = FB_W / WORD_W;   // words per framebuffer row
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned HS_LO   = H_ACTIVE + H_FP;
  localparam int unsigned HS_HI   = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_LO   = V_ACTIVE + V_FP;
  localparam int unsigned VS_HI   = V_ACTIVE + V_FP + V_SYNC;

  // Raster counters
  logic [HW-1:0] h;
  logic [VW-1:0] v;

  always_ff @(posedge clk) begin
    if (reset) begin
      h <= '0;
      v <= '0;
    end else if (h == HW'(H_TOTAL - 1)) begin
      h <= '0;
      v <= (v == VW'(V_TOTAL - 1)) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  // Display-slot decode.
  // A slot sits two cycles before the first pixel of its word: one cycle of
  // RAM latency, then one cycle to register into the shifter. Looking at h+2
  // (mod H_TOTAL) gives the word column directly. When h+2 wraps, the slot
  // belongs to the following line, or to row 0 if this is the last line of
  // the frame.
  int unsigned hx, vx, hp2, row, slot_k;
  logic        slot_hit;
  logic [ADDR_W-1:0] scan_addr;

  always_comb begin
    hx  = 32'(h);
    vx  = 32'(v);
    hp2 = hx + 32'd2;
    row = vx;
    if (hp2 >= H_TOTAL) begin
      hp2 = hp2 - H_TOTAL;
      row = (vx == V_TOTAL - 1) ? 32'd0 : vx + 32'd1;
    end
    slot_k    = hp2 / WORD_W;
    slot_hit  = !reset && (hp2 % WORD_W == 32'd0) && (slot_k < WPR) && (row < FB_H);
    scan_addr = ADDR_W'(row * WPR + slot_k);
  end

  // Memory port arbitration: the scanout owns the port in slot cycles, and
  // the CPU owns it otherwise. Reset blocks CPU writes.
  logic accept;

  always_comb begin
    accept    = !slot_hit && !reset;
    cpu_busy  = slot_hit;
    mem_addr  = slot_hit ? scan_addr : cpu_addr;
    mem_we    = accept && cpu_load;
    mem_wdata = cpu_din;
  end

  // Palette
  logic [11:0] fg_q, bg_q;

`ifdef SCREEN_PALETTE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fg_q <= 12'hFFF;
      bg_q <= 12'h000;
    end else if (h == '0 && v == VW'(V_TOTAL - 1)) begin
      fg_q <= fg_rgb;
      bg_q <= bg_rgb;
    end
  end
`else
  logic unused_palette;
  assign fg_q           = 12'hFFF;
  assign bg_q           = 12'h000;
  assign unused_palette = ^{fg_rgb, bg_rgb};
`endif

  // Fetch/read pipeline, pixel shifter and registered video outputs.
  // fetch_q and rd_q mark the cycle in which mem_rdata holds the word
  // requested one cycle earlier. They never coincide, because a slot cycle
  // is never an accepted CPU cycle.
  logic              fetch_q;
  logic              rd_q;
  logic [WORD_W-1:0] shifter;
  logic [11:0]       rgb_q;
  logic              in_fb;

  always_comb begin
    in_fb = (hx < FB_W) && (vx < FB_H) && (hx < H_ACTIVE) && (vx < V_ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_q  <= 1'b0;
      rd_q     <= 1'b0;
      shifter  <= '0;
      cpu_dout <= '0;
      rgb_q    <= '0;
      h_sync   <= 1'b1;
      v_sync   <= 1'b1;
    end else begin
      fetch_q <= slot_hit;
      rd_q    <= accept && !cpu_load;
      if (rd_q) begin
        cpu_dout <= mem_rdata;
      end
      // Loading the next word overrides the shift of the previous word's
      // last pixel. This keeps the pixel stream seamless across words.
      if (fetch_q) begin
        shifter <= mem_rdata;
      end else begin
        shifter <= shifter >> 1;
      end
      rgb_q  <= in_fb ? (shifter[0] ? fg_q : bg_q) : 12'h000;
      h_sync <= !((hx >= HS_LO) && (hx < HS_HI));
      v_sync <= !((vx >= VS_LO) && (vx < VS_HI));
    end
  end

  always_comb begin
    red   = rgb_q[11:8];
    green = rgb_q[7:4];
    blue  = rgb_q[3:0];
  end

endmodule
